// File: rtl/mul_issue_sched_pkg.sv
// Shared definitions for the multiplier issue scheduler.
//   SQN_W       : sequence-number width (modular, signed-difference ordering)
//   MAX_IF      : in-flight multiply ops tracked by the completion FIFO
//   CNT_W       : width of the in-flight count
//   sqn_younger : a is younger than b under modular ordering
package mul_issue_sched_pkg;

    localparam int SQN_W  = 7;
    localparam int MAX_IF = 2;
    localparam int CNT_W  = $clog2(MAX_IF + 1);

    function automatic logic sqn_younger(input logic [SQN_W-1:0] a,
                                         input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] d;
        d = a - b;
        return $signed(d) > 0;
    endfunction

endpackage

// File: rtl/mul_sqn_tracker.sv
// FIFO of in-flight multiply sqNs, oldest at entry 0.
//   push/push_sqn   : record a launched op (tail)
//   pop             : oldest op completed (ignored when empty)
//   flush/flush_sqn : drop every entry from the first one younger than flush_sqn
//   count           : number of valid entries
// Order within one edge: pop, then flush, then push.
module mul_sqn_tracker
    import mul_issue_sched_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [SQN_W-1:0] push_sqn,
    input  logic             pop,
    input  logic             flush,
    input  logic [SQN_W-1:0] flush_sqn,
    output logic [CNT_W-1:0] count
);

    logic [SQN_W-1:0] ent   [MAX_IF];
    logic [SQN_W-1:0] ent_p [MAX_IF];
    logic [SQN_W-1:0] ent_n [MAX_IF];
    logic [CNT_W-1:0] cnt_p;
    logic [CNT_W-1:0] cnt_n;
    logic             alive;

    always_comb begin
        ent_p = ent;
        cnt_p = count;
        if (pop && count != '0) begin
            for (int i = 0; i < MAX_IF - 1; i++) ent_p[i] = ent[i + 1];
            cnt_p = count - 1'b1;
        end

        // Survivors are the older prefix: stop counting at the first young entry.
        cnt_n = cnt_p;
        alive = 1'b1;
        if (flush) begin
            cnt_n = '0;
            for (int i = 0; i < MAX_IF; i++) begin
                if (alive && CNT_W'(i) < cnt_p && !sqn_younger(ent_p[i], flush_sqn))
                    cnt_n = CNT_W'(i + 1);
                else
                    alive = 1'b0;
            end
        end

        ent_n = ent_p;
        if (push && cnt_n < CNT_W'(MAX_IF)) begin
            for (int i = 0; i < MAX_IF; i++)
                if (cnt_n == CNT_W'(i)) ent_n[i] = push_sqn;
            cnt_n = cnt_n + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) count <= '0;
        else     count <= cnt_n;
        ent <= ent_n;
    end

endmodule

// File: rtl/mul_issue_sched.sv
// Age-ordered issue scheduler in front of the shared iterative multiplier.
//   IN_valid/IN_sqN/IN_uop/OUT_ready : two issue ports, oldest non-killed wins
//   IN_branchValid/IN_branchSqN      : mispredict flush of younger work
//   IN_mulBusy/OUT_mulEn/OUT_mulUop  : launch of the staged uop
//   IN_mulDone/OUT_inFlight          : completion tracking
//   OUT_idle                         : stage empty and nothing in flight
//   OUT_err                          : sticky done-on-empty / push-on-full
module mul_issue_sched
    import mul_issue_sched_pkg::*;
#(
    parameter int UOP_W = 199
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           IN_valid,
    input  logic [2*SQN_W-1:0]   IN_sqN,
    input  logic [2*UOP_W-1:0]   IN_uop,
    output logic [1:0]           OUT_ready,
    input  logic                 IN_branchValid,
    input  logic [SQN_W-1:0]     IN_branchSqN,
    input  logic                 IN_mulBusy,
    output logic                 OUT_mulEn,
    output logic [UOP_W-1:0]     OUT_mulUop,
    input  logic                 IN_mulDone,
    output logic [1:0]           OUT_inFlight,
    output logic                 OUT_idle,
    output logic                 OUT_err
);

    logic             stg_valid;
    logic [SQN_W-1:0] stg_sqn;
    logic             rr_ptr;
    logic [CNT_W-1:0] if_cnt;

    logic [SQN_W-1:0] sqn0, sqn1, age_d;
    logic             kill_stg, can_accept, win1, tie, grant;
    logic [1:0]       req_ok;

    assign sqn0 = IN_sqN[SQN_W-1:0];
    assign sqn1 = IN_sqN[2*SQN_W-1:SQN_W];
    assign age_d = sqn0 - sqn1;

    assign kill_stg  = stg_valid && IN_branchValid && sqn_younger(stg_sqn, IN_branchSqN);
    assign OUT_mulEn = !rst && stg_valid && !IN_mulBusy && !kill_stg
                       && if_cnt < CNT_W'(MAX_IF);
    assign can_accept = !stg_valid || OUT_mulEn || kill_stg;

    assign req_ok[0] = IN_valid[0] && !(IN_branchValid && sqn_younger(sqn0, IN_branchSqN));
    assign req_ok[1] = IN_valid[1] && !(IN_branchValid && sqn_younger(sqn1, IN_branchSqN));

    always_comb begin
        win1 = req_ok[1];
        tie  = 1'b0;
        if (req_ok[0] && req_ok[1]) begin
            if (age_d == '0) begin
                tie  = 1'b1;
                win1 = rr_ptr;
            end else begin
                win1 = sqn_younger(sqn0, sqn1);
            end
        end
    end

    assign grant     = !rst && (|req_ok) && can_accept;
    assign OUT_ready = grant ? (win1 ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_valid <= 1'b0;
            rr_ptr    <= 1'b0;
            OUT_err   <= 1'b0;
        end else begin
            if (grant) begin
                stg_valid  <= 1'b1;
                stg_sqn    <= win1 ? sqn1 : sqn0;
                OUT_mulUop <= win1 ? IN_uop[2*UOP_W-1:UOP_W] : IN_uop[UOP_W-1:0];
                if (tie) rr_ptr <= !rr_ptr;
            end else if (OUT_mulEn || kill_stg) begin
                stg_valid <= 1'b0;
            end
            if ((IN_mulDone && if_cnt == '0) || (OUT_mulEn && if_cnt >= CNT_W'(MAX_IF)))
                OUT_err <= 1'b1;
        end
    end

    mul_sqn_tracker u_trk (
        .clk       (clk),
        .rst       (rst),
        .push      (OUT_mulEn),
        .push_sqn  (stg_sqn),
        .pop       (IN_mulDone),
        .flush     (IN_branchValid),
        .flush_sqn (IN_branchSqN),
        .count     (if_cnt)
    );

    assign OUT_inFlight = 2'(if_cnt);
    assign OUT_idle     = !stg_valid && if_cnt == '0;

endmodule
